// File: rtl/ajit_acc_dma_pkg.sv
// Shared definitions for the AJIT accelerator DMA engine.
//   - FSM state encoding
//   - ACB memory request/response field positions
//   - fixed request field values (full byte mask)
package ajit_acc_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_RSP,
    S_WR_REQ,
    S_WR_RSP,
    S_FINISH,
    S_FAIL
  } dma_state_e;

  localparam int ADDR_W   = 36;
  localparam int DATA_W   = 64;
  localparam int REQ_W    = 110;
  localparam int RSP_W    = 65;

  // request pipe fields
  localparam int LOCK_BIT = 109;
  localparam int RW_BIT   = 108;
  localparam int MASK_HI  = 107;
  localparam int MASK_LO  = 100;
  localparam int ADDR_HI  = 99;
  localparam int ADDR_LO  = 64;

  // response pipe fields
  localparam int ERR_BIT  = 64;

  localparam logic [7:0]        FULL_MASK  = 8'hFF;
  localparam logic [ADDR_W-1:0] WORD_BYTES = 36'd8;
  localparam logic [ADDR_W-1:0] ADDR_ALIGN = 36'h7;

endpackage

// File: rtl/ajit_acc_dma_engine_fifo.sv
// acc_dma_fifo: synchronous FIFO buffering one read burst of the DMA engine.
//   clk, rst (async, active-high)
//   push/wdata  : write one word (ignored when full)
//   pop/rdata   : rdata is the head word (show-ahead), pop drops it
//   flush       : empties the FIFO on the next edge
//   full, empty, level : occupancy status
module acc_dma_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // one extra pointer bit tells full apart from empty
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ajit_acc_dma_engine.sv
// ajit_acc_dma_engine: memory-side copy engine of the AJIT accelerator.
// Copies cmd_word_count 64-bit words from cmd_src_addr to cmd_dst_addr in
// bursts of up to FIFO_DEPTH words, one ACB request outstanding at a time.
//   clk, reset (async, active-high)
//   cmd_*       : start pulse and copy parameters from the command block
//   irq_clear   : clears sticky done/error
//   busy, done, error, words_done : status back to the command block
//   ACB_ACCELERATOR_MEM_REQUEST_*  : request pipe (engine -> memory)
//   ACB_ACCELERATOR_MEM_RESPONSE_* : response pipe (memory -> engine)
//   ACCELERATOR_INTERRUPT = done | error
module ajit_acc_dma_engine
  import ajit_acc_dma_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_start,
  input  logic [35:0]        cmd_src_addr,
  input  logic [35:0]        cmd_dst_addr,
  input  logic [CNT_W-1:0]   cmd_word_count,
  input  logic               irq_clear,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [CNT_W-1:0]   words_done,
  output logic [109:0]       ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data,
  input  logic               ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req,
  output logic               ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack,
  input  logic [64:0]        ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data,
  input  logic               ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req,
  output logic               ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack,
  output logic               ACCELERATOR_INTERRUPT
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  dma_state_e        state;
  logic [ADDR_W-1:0] src_addr, dst_addr;
  logic [CNT_W-1:0]  rd_left;
  logic              req_vld, rsp_rdy;
  logic              req_xfer, rsp_xfer, rsp_err;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;
  logic [LVL_W-1:0]  fifo_level;
  logic              fifo_push, fifo_pop, fifo_last;
  logic [REQ_W-1:0]  req_data;

  assign req_xfer = req_vld & ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req;
  assign rsp_xfer = rsp_rdy & ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req;
  assign rsp_err  = ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data[ERR_BIT];

  assign fifo_push = rsp_xfer && (state == S_RD_RSP) && !rsp_err;
  assign fifo_pop  = req_xfer && (state == S_WR_REQ);
  // the word being pushed now takes the last free slot
  assign fifo_last = (fifo_level == LVL_W'(FIFO_DEPTH - 1));

  acc_dma_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (state == S_FAIL),
    .wdata (ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data[DATA_W-1:0]),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Request fields come only from registers held constant in RD_REQ/WR_REQ,
  // so data stays stable while ack waits. Gated to zero when idle.
  always_comb begin
    req_data = '0;
    if (req_vld) begin
      req_data[LOCK_BIT]        = 1'b0;
      req_data[RW_BIT]          = (state == S_RD_REQ);
      req_data[MASK_HI:MASK_LO] = FULL_MASK;
      req_data[ADDR_HI:ADDR_LO] = (state == S_RD_REQ) ? src_addr : dst_addr;
      if (state == S_WR_REQ) req_data[DATA_W-1:0] = fifo_head;
    end
  end

  assign ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data  = req_data;
  assign ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack   = req_vld;
  assign ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack = rsp_rdy;
  assign ACCELERATOR_INTERRUPT = done | error;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      src_addr   <= '0;
      dst_addr   <= '0;
      rd_left    <= '0;
      words_done <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      req_vld    <= 1'b0;
      rsp_rdy    <= 1'b0;
    end else begin
      // FINISH/FAIL below override this, so a same-cycle set wins
      if (irq_clear) begin
        done  <= 1'b0;
        error <= 1'b0;
      end
      case (state)
        S_IDLE: if (cmd_start) begin
          src_addr   <= cmd_src_addr & ~ADDR_ALIGN;
          dst_addr   <= cmd_dst_addr & ~ADDR_ALIGN;
          rd_left    <= cmd_word_count;
          words_done <= '0;
          done       <= 1'b0;
          error      <= 1'b0;
          busy       <= 1'b1;
          if (cmd_word_count == '0) begin
            state <= S_FINISH;
          end else begin
            state   <= S_RD_REQ;
            req_vld <= 1'b1;
          end
        end
        S_RD_REQ: if (req_xfer) begin
          state   <= S_RD_RSP;
          req_vld <= 1'b0;
          rsp_rdy <= 1'b1;
        end
        S_RD_RSP: if (rsp_xfer) begin
          rsp_rdy <= 1'b0;
          if (rsp_err) begin
            state <= S_FAIL;
          end else begin
            src_addr <= src_addr + WORD_BYTES;
            rd_left  <= rd_left - CNT_W'(1);
            req_vld  <= 1'b1;
            state    <= (fifo_last || rd_left == CNT_W'(1)) ? S_WR_REQ : S_RD_REQ;
          end
        end
        S_WR_REQ: if (req_xfer) begin
          state   <= S_WR_RSP;
          req_vld <= 1'b0;
          rsp_rdy <= 1'b1;
        end
        S_WR_RSP: if (rsp_xfer) begin
          rsp_rdy <= 1'b0;
          if (rsp_err) begin
            state <= S_FAIL;
          end else begin
            dst_addr   <= dst_addr + WORD_BYTES;
            words_done <= words_done + CNT_W'(1);
            // fifo_empty already reflects the pop done in WR_REQ
            if (!fifo_empty) begin
              state   <= S_WR_REQ;
              req_vld <= 1'b1;
            end else if (rd_left != '0) begin
              state   <= S_RD_REQ;
              req_vld <= 1'b1;
            end else begin
              state <= S_FINISH;
            end
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        S_FAIL: begin
          busy  <= 1'b0;
          error <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // fifo_full is kept for visibility; burst end is decided one push early
  logic unused_full;
  assign unused_full = fifo_full;

endmodule
